// File: rtl/add_shift_multiplier.sv
// Sequential signed add-shift multiplier: {Aval,Bval} <= multiplicand * multiplier
// after 2*WIDTH cycles, using a WIDTH+1-bit ripple-carry add/subtract datapath.
`timescale 1ns/1ps
module add_shift_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Run,
    input  logic             ClearA_LoadB,
    input  logic [WIDTH-1:0] Din,
    output logic [WIDTH-1:0] Aval,
    output logic [WIDTH-1:0] Bval,
    output logic             X,
    output logic             Busy
);

    localparam int K_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [K_W-1:0] K_LAST = K_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADD   = 2'd1,
        SHIFT = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t                  state;
    logic signed [WIDTH-1:0] a_reg;
    logic signed [WIDTH-1:0] b_reg;
    logic signed [WIDTH-1:0] m_reg;
    logic                    x_reg;
    logic                    busy_reg;
    logic [K_W-1:0]          k_cnt;

    logic                    sub_op;
    logic signed [WIDTH:0]   add_a;
    logic signed [WIDTH:0]   add_b;
    logic signed [WIDTH:0]   add_sum;

    // One bit-level full-adder cell: returns {carry_out, sum}.
    function automatic logic [1:0] fa_cell(input logic a, input logic b, input logic cin);
        return {(a & b) | (cin & (a ^ b)), a ^ b ^ cin};
    endfunction

    // The last multiplier bit carries negative weight, so that step subtracts M.
    assign sub_op = (k_cnt == K_LAST);
    assign add_a  = {a_reg[WIDTH-1], a_reg};
    assign add_b  = sub_op ? ~{m_reg[WIDTH-1], m_reg} : {m_reg[WIDTH-1], m_reg};

    always_comb begin
        logic cy;
        cy      = sub_op;
        add_sum = '0;
        for (int j = 0; j <= WIDTH; j++) begin
            {cy, add_sum[j]} = fa_cell(add_a[j], add_b[j], cy);
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state    <= IDLE;
            a_reg    <= '0;
            b_reg    <= '0;
            m_reg    <= '0;
            x_reg    <= 1'b0;
            busy_reg <= 1'b0;
            k_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ClearA_LoadB) begin
                        a_reg <= '0;
                        x_reg <= 1'b0;
                        b_reg <= Din;
                    end else if (Run) begin
                        a_reg    <= '0;
                        x_reg    <= 1'b0;
                        m_reg    <= Din;
                        k_cnt    <= '0;
                        busy_reg <= 1'b1;
                        state    <= ADD;
                    end
                end
                ADD: begin
                    // Carry out of the top cell is dropped; X takes the sign-extension bit.
                    if (b_reg[0]) begin
                        {x_reg, a_reg} <= add_sum;
                    end
                    state <= SHIFT;
                end
                SHIFT: begin
                    a_reg <= {x_reg, a_reg[WIDTH-1:1]};
                    b_reg <= {a_reg[0], b_reg[WIDTH-1:1]};
                    if (k_cnt == K_LAST) begin
                        busy_reg <= 1'b0;
                        state    <= HOLD;
                    end else begin
                        k_cnt <= k_cnt + K_W'(1);
                        state <= ADD;
                    end
                end
                HOLD: begin
                    // Run must drop before another start can be accepted.
                    if (!Run) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign Aval = a_reg;
    assign Bval = b_reg;
    assign X    = x_reg;
    assign Busy = busy_reg;

endmodule

// File: tb/tb_add_shift_multiplier.sv
// Bench for add_shift_multiplier: directed vectors, a product-level reference
// model checked every cycle, and literal expectations for the key cases.
`timescale 1ns/1ps
module tb_add_shift_multiplier;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         run;
    logic         clr_ld;
    logic [W-1:0] din;
    logic [W-1:0] aval;
    logic [W-1:0] bval;
    logic         x;
    logic         busy;

    int n_vec = 0;
    int n_err = 0;
    logic armed = 1'b0;

    add_shift_multiplier #(.WIDTH(W)) dut (
        .Clk          (clk),
        .Reset_n      (rst_n),
        .Run          (run),
        .ClearA_LoadB (clr_ld),
        .Din          (din),
        .Aval         (aval),
        .Bval         (bval),
        .X            (x),
        .Busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: knows only "product of B and Din at start, ready 2*W cycles later".
    logic [W-1:0]          m_a;
    logic [W-1:0]          m_b;
    logic                  m_x;
    logic                  m_busy;
    logic                  m_hold;
    logic                  m_valid;
    int                    m_left;
    logic signed [2*W-1:0] m_prod;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_a <= '0; m_b <= '0; m_x <= 1'b0;
            m_busy <= 1'b0; m_hold <= 1'b0; m_valid <= 1'b1;
            m_left <= 0; m_prod <= '0;
        end else if (m_busy) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_busy  <= 1'b0;
                m_hold  <= 1'b1;
                m_valid <= 1'b1;
                {m_a, m_b} <= m_prod;
                m_x     <= m_prod[2*W-1];
            end
        end else if (m_hold) begin
            if (!run) m_hold <= 1'b0;
        end else if (clr_ld) begin
            m_a <= '0; m_x <= 1'b0; m_b <= din;
        end else if (run) begin
            m_prod  <= $signed(m_b) * $signed(din);
            m_busy  <= 1'b1;
            m_left  <= 2 * W;
            m_valid <= 1'b0;
            m_a <= '0; m_x <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            chk("busy", 32'(busy), 32'(m_busy));
            if (m_valid) begin
                chk("aval", 32'(aval), 32'(m_a));
                chk("bval", 32'(bval), 32'(m_b));
                chk("x", 32'(x), 32'(m_x));
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_load(input logic [W-1:0] v);
        clr_ld = 1'b1; din = v;
        tick();
        clr_ld = 1'b0;
    endtask

    task automatic do_start(input logic [W-1:0] v);
        run = 1'b1; din = v;
        tick();
        run = 1'b0;
    endtask

    // Counts busy cycles until done; an expired bound is reported as a miscompare.
    task automatic wait_done(output int cnt);
        cnt = 0;
        while (busy === 1'b1 && cnt < 100) begin
            cnt++;
            tick();
        end
        if (cnt >= 100) begin
            n_vec++; n_err++;
            $display("FAIL timeout: busy still high after %0d cycles", cnt);
        end
    endtask

    task automatic run_mult(input logic [W-1:0] mult, input logic [W-1:0] mcand,
                            input logic [2*W-1:0] exp_p, input logic exp_x, input string nm);
        int cnt;
        do_load(mult);
        do_start(mcand);
        wait_done(cnt);
        chk({nm, "_cycles"}, 32'(cnt), 32'(2 * W));
        chk({nm, "_prod"}, 32'({aval, bval}), 32'(exp_p));
        chk({nm, "_x"}, 32'(x), 32'(exp_x));
        chk({nm, "_model"}, 32'({m_a, m_b}), 32'(exp_p));
        tick();
    endtask

    initial begin
        int cnt;
        int bcnt;
        rst_n = 1'b0; run = 1'b0; clr_ld = 1'b0; din = '0;
        tick(); tick();
        armed = 1'b1;
        chk("rst_aval", 32'(aval), 32'h0);
        chk("rst_bval", 32'(bval), 32'h0);
        chk("rst_x", 32'(x), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        rst_n = 1'b1;
        tick();

        // -3 * 7 = -21
        run_mult(8'hFD, 8'h07, 16'hFFEB, 1'b1, "basic");
        // -128 * -128 = 16384
        run_mult(8'h80, 8'h80, 16'h4000, 1'b0, "minmin");
        // 127 * -128 = -16256
        run_mult(8'h7F, 8'h80, 16'hC080, 1'b1, "maxmin");
        // zero multiplier
        run_mult(8'h00, 8'h5A, 16'h0000, 1'b0, "zero");

        // Run held high: exactly one multiply, 3 * 5 = 15
        do_load(8'h03);
        run = 1'b1; din = 8'h05;
        bcnt = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (busy === 1'b1) bcnt++;
        end
        chk("hold_busycnt", 32'(bcnt), 32'd16);
        chk("hold_prod", 32'({aval, bval}), 32'h000F);
        run = 1'b0;
        tick();
        // Restart on the edge after returning to IDLE: 15 * -2 = -30
        run = 1'b1; din = 8'hFE;
        tick();
        chk("restart_busy", 32'(busy), 32'h1);
        run = 1'b0;
        wait_done(cnt);
        chk("restart_prod", 32'({aval, bval}), 32'hFFE2);
        tick();

        // Disturbed run: -13 * 9 = -117, ClearA_LoadB and Din toggled while busy
        do_load(8'hF3);
        do_start(8'h09);
        for (int i = 0; i < 6; i++) begin
            clr_ld = i[0]; din = 8'(i * 37 + 1);
            tick();
        end
        clr_ld = 1'b0;
        wait_done(cnt);
        chk("ignore_prod", 32'({aval, bval}), 32'hFF8B);
        chk("ignore_x", 32'(x), 32'h1);
        tick();

        // Run and ClearA_LoadB together in IDLE: load only
        run = 1'b1; clr_ld = 1'b1; din = 8'h11;
        tick();
        run = 1'b0; clr_ld = 1'b0;
        chk("both_busy", 32'(busy), 32'h0);
        chk("both_bval", 32'(bval), 32'h11);
        chk("both_aval", 32'(aval), 32'h0);
        tick();

        // Reset mid-operation, then a fresh multiply: -5 * 11 = -55
        do_load(8'h06);
        do_start(8'h07);
        repeat (6) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_aval", 32'(aval), 32'h0);
        chk("midrst_bval", 32'(bval), 32'h0);
        chk("midrst_x", 32'(x), 32'h0);
        chk("midrst_busy", 32'(busy), 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        run_mult(8'hFB, 8'h0B, 16'hFFC9, 1'b1, "postrst");

        repeat (3) tick();
        armed = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
